// File: rtl/hwt_sweep_ctrl.sv
// hwt_sweep_ctrl: exhaustive 16-vector sweep of the Y = D & ((A & B) | C) cell.
// Drives each vector, holds it SETTLE_CYCLES cycles, samples dut_y once,
// compares with a golden model and counts mismatches.
// Optional macro HWT_FAIL_CAPTURE_EN adds first-failing-vector capture ports.
module hwt_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  output logic       dut_d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] mism_cnt
`ifdef HWT_FAIL_CAPTURE_EN
  ,
  output logic [3:0] first_fail_vec,
  output logic       first_fail_valid
`endif
);

  localparam int unsigned VEC_W  = 4;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned CNT_W  = 5;

  localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0]  VEC_LAST    = VEC_W'(15);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   mism_d;
  logic               pass_d;
  logic               done_d;
  logic               busy_d;
  logic [VEC_W-1:0]   drv_d;
  logic               golden_c;
`ifdef HWT_FAIL_CAPTURE_EN
  logic [VEC_W-1:0]   ffv_d;
  logic               ffvalid_d;
`endif

  // Golden model of the cell for the vector currently applied.
  assign golden_c = vec_q[0] & ((vec_q[3] & vec_q[2]) | vec_q[1]);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wait_d  = wait_q;
    mism_d  = mism_cnt;
    pass_d  = pass;
    done_d  = 1'b0;
`ifdef HWT_FAIL_CAPTURE_EN
    ffv_d     = first_fail_vec;
    ffvalid_d = first_fail_valid;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_DRIVE;
          vec_d   = '0;
          wait_d  = '0;
          mism_d  = '0;
          pass_d  = 1'b0;
`ifdef HWT_FAIL_CAPTURE_EN
          ffv_d     = '0;
          ffvalid_d = 1'b0;
`endif
        end
      end

      ST_DRIVE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q == SETTLE_LAST) begin
            state_d = ST_SAMPLE;
          end
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          if (dut_y != golden_c) begin
            mism_d = mism_cnt + CNT_W'(1);
`ifdef HWT_FAIL_CAPTURE_EN
            if (!first_fail_valid) begin
              ffv_d     = vec_q;
              ffvalid_d = 1'b1;
            end
`endif
          end
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
          end else begin
            vec_d   = vec_q + VEC_W'(1);
            wait_d  = '0;
            state_d = ST_DRIVE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        if (!abort) begin
          done_d = 1'b1;
          pass_d = (mism_cnt == '0);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
    drv_d  = busy_d ? vec_d : '0;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      wait_q   <= '0;
      dut_a    <= 1'b0;
      dut_b    <= 1'b0;
      dut_c    <= 1'b0;
      dut_d    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      mism_cnt <= '0;
`ifdef HWT_FAIL_CAPTURE_EN
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      wait_q   <= wait_d;
      dut_a    <= drv_d[3];
      dut_b    <= drv_d[2];
      dut_c    <= drv_d[1];
      dut_d    <= drv_d[0];
      busy     <= busy_d;
      done     <= done_d;
      pass     <= pass_d;
      mism_cnt <= mism_d;
`ifdef HWT_FAIL_CAPTURE_EN
      first_fail_vec   <= ffv_d;
      first_fail_valid <= ffvalid_d;
`endif
    end
  end

endmodule

// File: tb/tb_hwt_sweep_ctrl.sv
// Self-checking bench for hwt_sweep_ctrl (SETTLE_CYCLES = 2).
module tb_hwt_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       dut_y;
  logic       dut_a, dut_b, dut_c, dut_d;
  logic       busy, done, pass;
  logic [4:0] mism_cnt;
`ifdef HWT_FAIL_CAPTURE_EN
  logic [3:0] first_fail_vec;
  logic       first_fail_valid;
`endif

  int y_mode = 0;  // 0 golden, 1 stuck-at-0, 2 stuck-at-1, 3 trojan at 1010
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Behavioural models of the cell under test, driven from the pins.
  logic [3:0] pins;
  logic       cell_ok;
  assign pins    = {dut_a, dut_b, dut_c, dut_d};
  assign cell_ok = dut_d & ((dut_a & dut_b) | dut_c);
  assign dut_y   = (y_mode == 1) ? 1'b0 :
                   (y_mode == 2) ? 1'b1 :
                   (y_mode == 3) ? (cell_ok ^ (pins == 4'b1010)) : cell_ok;

  hwt_sweep_ctrl #(.SETTLE_CYCLES(2)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .dut_y    (dut_y),
    .dut_a    (dut_a),
    .dut_b    (dut_b),
    .dut_c    (dut_c),
    .dut_d    (dut_d),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .mism_cnt (mism_cnt)
`ifdef HWT_FAIL_CAPTURE_EN
    ,
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
`endif
  );

  typedef struct {
    string name;
    int    mode;
    int    restart_at;  // edge index at which a stray start is pulsed, 0 = none
    int    exp_mism;
    int    exp_pass;
    int    exp_ffv;
    int    exp_ffvalid;
  } sweep_vec_t;

  sweep_vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one full sweep and check timing, drive sequence and results.
  task automatic run_sweep(input sweep_vec_t v);
    int latency;
    int bad;
    int exp_pins;
    latency = 0;
    bad = 0;
    y_mode = v.mode;
    @(negedge clk);
    start = 1'b1;
    step();  // edge 0 samples start
    start = 1'b0;
    if (!busy || pins != 4'd0) bad++;
    for (int n = 1; n <= 200 && latency == 0; n++) begin
      start = (n == v.restart_at);
      step();
      start = 1'b0;
      exp_pins = (n < 48) ? n / 3 : 0;
      if (int'(pins) != exp_pins || busy != (n < 48)) bad++;
      if (done) latency = n;
    end
    check({v.name, "_drive_seq"}, bad, 0);
    check({v.name, "_done_latency"}, latency, 49);
    check({v.name, "_mism_cnt"}, int'(mism_cnt), v.exp_mism);
    check({v.name, "_pass"}, int'(pass), v.exp_pass);
`ifdef HWT_FAIL_CAPTURE_EN
    check({v.name, "_ff_valid"}, int'(first_fail_valid), v.exp_ffvalid);
    if (v.exp_ffvalid != 0) check({v.name, "_ff_vec"}, int'(first_fail_vec), v.exp_ffv);
`endif
    step();
    check({v.name, "_done_width"}, int'(done), 0);
  endtask

  initial begin
    int done_seen;
    tbl[0] = '{"golden",   0,  0,  0, 1,  0, 0};
    tbl[1] = '{"stuck0",   1,  0,  5, 0,  3, 1};
    tbl[2] = '{"stuck1",   2,  0, 11, 0,  0, 1};
    tbl[3] = '{"trojan",   3,  0,  1, 0, 10, 1};
    tbl[4] = '{"restart",  0, 10,  0, 1,  0, 0};
    tbl[5] = '{"late_st",  0, 48,  0, 1,  0, 0};

    // Reset state.
    #12;
    check("rst_pins", int'(pins), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_mism", int'(mism_cnt), 0);
`ifdef HWT_FAIL_CAPTURE_EN
    check("rst_ff_valid", int'(first_fail_valid), 0);
    check("rst_ff_vec", int'(first_fail_vec), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_sweep(tbl[i]);

    // Abort while vec = 6 (stuck-at-0 cell: only vec 3 mismatched so far).
    y_mode = 1;
    @(negedge clk);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 18; n++) step();
    check("abort_pre_pins", int'(pins), 6);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_pins", int'(pins), 0);
    done_seen = 0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_pass", int'(pass), 0);
    check("abort_mism", int'(mism_cnt), 1);
`ifdef HWT_FAIL_CAPTURE_EN
    check("abort_ff_vec", int'(first_fail_vec), 3);
`endif

    // start and abort together in IDLE: no sweep.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    done_seen = 0;
    for (int n = 0; n < 4; n++) begin
      if (busy || pins != 4'd0) done_seen++;
      step();
    end
    check("start_abort_idle", done_seen, 0);
    check("start_abort_mism", int'(mism_cnt), 1);

    // Reset pulsed during the vec-1 SAMPLE cycle of a stuck-at-1 sweep.
    y_mode = 2;
    @(negedge clk);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 5; n++) step();
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_pins", int'(pins), 1);
    check("pre_rst_mism", int'(mism_cnt), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_pins", int'(pins), 0);
    check("async_rst_mism", int'(mism_cnt), 0);
`ifdef HWT_FAIL_CAPTURE_EN
    check("async_rst_ff_valid", int'(first_fail_valid), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_sweep(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
